delay_pipe_credit_sink: RTL and testbench

- Downstream companion to the static delay pipe.
- The delay pipe's output is valid-only and cannot be stalled. This block catches that output in a receive FIFO and presents it to the consumer as a valid/accept stream with backpressure.
- It also owns the credit counter that gates issue into the delay pipe, so the FIFO never overflows regardless of pipe latency.
- Sits at the tail of the delay pipe; the issue-side handshake wraps around to the pipe's head.

---
 rtl/delay_pipe_credit_sink_if.sv | 23 ++
 rtl/delay_pipe_credit_sink.sv | 74 +++++++
 tb/tb_delay_pipe_credit_sink.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/delay_pipe_credit_sink_if.sv
// Stream bundle between the delay pipe tail, the issue side and the consumer.
// The master drives issue requests, pipe output and consumer accept. The slave is the sink.
interface delay_pipe_credit_sink_if #(
  parameter int W = 32
);
  logic         issue_vld;
  logic         issue_ok;
  logic [W-1:0] in;
  logic         in_vld;
  logic [W-1:0] out;
  logic         out_vld;
  logic         out_accept;

  modport master (
    output issue_vld, in, in_vld, out_accept,
    input  issue_ok, out, out_vld
  );

  modport slave (
    input  issue_vld, in, in_vld, out_accept,
    output issue_ok, out, out_vld
  );
endinterface

// File: rtl/delay_pipe_credit_sink.sv
// Receive FIFO and issue-credit counter at the tail of a non-stallable delay pipe.
// Each credit stands for one FIFO slot, so items issued against credits always find room.
module delay_pipe_credit_sink #(
  parameter  int W     = 32,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  delay_pipe_credit_sink_if.slave       bus,
  output logic                          overflow_r,
  output logic [CW-1:0]                 credit_r
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic full;
  logic issue;
  logic deq;
  logic wr;

  assign full         = (count == CW'(DEPTH));
  assign bus.out_vld  = (count != '0);
  assign bus.out      = mem[rd_ptr];
  assign bus.issue_ok = (credit_r != '0);

  assign issue = bus.issue_vld & bus.issue_ok;
  assign deq   = bus.out_vld & bus.out_accept;
  // A pop in the same cycle frees the slot a write into a full FIFO needs.
  assign wr    = bus.in_vld & (~full | deq);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= bus.in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.in_vld & full & ~deq) overflow_r <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= CW'(DEPTH);
    end else begin
      case ({issue, deq})
        2'b10:   credit_r <= credit_r - 1'b1;
        2'b01:   credit_r <= credit_r + 1'b1;
        default: credit_r <= credit_r;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_pipe_credit_sink.sv
// Directed bench: a DEPTH=4 sink driven by hand, and a DEPTH=8 sink fed by a 5-cycle pipe model.
module tb_delay_pipe_credit_sink;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_pipe_credit_sink_if #(.W(8)) bus_a ();
  delay_pipe_credit_sink_if #(.W(8)) bus_b ();

  logic       ovf_a, ovf_b;
  logic [2:0] cred_a;
  logic [3:0] cred_b;

  delay_pipe_credit_sink #(.W(8), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .overflow_r(ovf_a), .credit_r(cred_a)
  );
  delay_pipe_credit_sink #(.W(8), .DEPTH(8)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .overflow_r(ovf_b), .credit_r(cred_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deliver_a(input logic [7:0] d);
    bus_a.in     = d;
    bus_a.in_vld = 1'b1;
    tick();
    bus_a.in_vld = 1'b0;
  endtask

  logic [7:0] vals [4];
  logic       pv [5];
  logic [7:0] pd [5];

  initial begin
    int n_iss;
    int sent, rcv, cnt_m, inflight;
    logic launch, wr_m, deq_m;

    bus_a.issue_vld = 0; bus_a.in = '0; bus_a.in_vld = 0; bus_a.out_accept = 0;
    bus_b.issue_vld = 0; bus_b.in = '0; bus_b.in_vld = 0; bus_b.out_accept = 0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_ok", bus_a.issue_ok, 1);
    chk("rst_vld", bus_a.out_vld, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_cred", cred_a, 4);
    chk("rst_cred_b", cred_b, 8);
    rst = 1'b0;

    // credit drain
    n_iss = 0;
    bus_a.issue_vld = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (bus_a.issue_ok) n_iss++;
      tick();
      chk("drain_cred", cred_a, (k < 4) ? 4 - k : 0);
      chk("drain_ok", bus_a.issue_ok, (k < 4) ? 1 : 0);
    end
    bus_a.issue_vld = 1'b0;
    chk("drain_issues", n_iss, 4);

    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      deliver_a(vals[i]);
      chk("fill_vld", bus_a.out_vld, 1);
      chk("fill_head", bus_a.out, 8'h11);
    end
    chk("fill_ovf", ovf_a, 0);

    // drain and return credits
    bus_a.out_accept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ret_vld", bus_a.out_vld, 1);
      chk("ret_data", bus_a.out, vals[i]);
      tick();
      chk("ret_cred", cred_a, i + 1);
      chk("ret_ok", bus_a.issue_ok, 1);
    end
    bus_a.out_accept = 1'b0;
    chk("ret_empty", bus_a.out_vld, 0);

    // simultaneous write and read while full
    bus_a.issue_vld = 1'b1;
    repeat (4) tick();
    bus_a.issue_vld = 1'b0;
    deliver_a(8'hA1); deliver_a(8'hA2); deliver_a(8'hA3); deliver_a(8'hA4);
    chk("full_cred", cred_a, 0);
    chk("full_ok", bus_a.issue_ok, 0);
    bus_a.in = 8'hAA; bus_a.in_vld = 1'b1; bus_a.out_accept = 1'b1;
    tick();
    bus_a.in_vld = 1'b0; bus_a.out_accept = 1'b0;
    chk("wrrd_head", bus_a.out, 8'hA2);
    chk("wrrd_ovf", ovf_a, 0);

    // forced overflow
    bus_a.in = 8'h55; bus_a.in_vld = 1'b1;
    tick();
    bus_a.in_vld = 1'b0;
    chk("ovf_set", ovf_a, 1);
    tick();
    chk("ovf_sticky", ovf_a, 1);
    chk("ovf_head", bus_a.out, 8'hA2);

    vals[0] = 8'hA2; vals[1] = 8'hA3; vals[2] = 8'hA4; vals[3] = 8'hAA;
    bus_a.out_accept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_vld", bus_a.out_vld, 1);
      chk("ovf_drain_data", bus_a.out, vals[i]);
      tick();
    end
    bus_a.out_accept = 1'b0;
    chk("ovf_drain_empty", bus_a.out_vld, 0);
    chk("ovf_hold", ovf_a, 1);

    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovf_clr", ovf_a, 0);
    chk("ovf_clr_cred", cred_a, 4);

    // reset mid-stream with count 3, credit 1
    bus_a.issue_vld = 1'b1;
    repeat (3) tick();
    bus_a.issue_vld = 1'b0;
    deliver_a(8'hB1); deliver_a(8'hB2); deliver_a(8'hB3);
    chk("mid_cred", cred_a, 1);
    chk("mid_vld", bus_a.out_vld, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_cred", cred_a, 4);
    chk("mid_rst_vld", bus_a.out_vld, 0);
    chk("mid_rst_ok", bus_a.issue_ok, 1);
    chk("mid_rst_ovf", ovf_a, 0);

    // full throughput through a 5-cycle pipe model
    for (int i = 0; i < 5; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    sent = 0; rcv = 0; cnt_m = 0;
    bus_b.out_accept = 1'b1;
    for (int cyc = 0; cyc < 100 && rcv < 50; cyc++) begin
      bus_b.issue_vld = (sent < 50);
      inflight = 0;
      for (int i = 0; i < 5; i++) inflight += pv[i];
      if (sent < 50) chk("tp_ok", bus_b.issue_ok, 1);
      chk("tp_inv", 32'(cred_b) + inflight + cnt_m, 8);
      chk("tp_vld", bus_b.out_vld, (cnt_m != 0) ? 1 : 0);
      if (cnt_m != 0) chk("tp_data", bus_b.out, 8'(rcv));
      if (rcv > 0 && rcv < 50) chk("tp_gap", bus_b.out_vld, 1);
      launch = bus_b.issue_vld & bus_b.issue_ok;
      wr_m   = pv[4];
      deq_m  = (cnt_m != 0);
      tick();
      cnt_m = cnt_m + int'(wr_m) - int'(deq_m);
      if (deq_m) rcv++;
      for (int i = 4; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = launch;
      pd[0] = 8'(sent);
      if (launch) sent++;
      bus_b.in_vld = pv[4];
      bus_b.in     = pd[4];
    end
    bus_b.issue_vld = 1'b0;
    bus_b.out_accept = 1'b0;
    chk("tp_count", rcv, 50);
    chk("tp_cred_end", cred_b, 8);
    chk("tp_ovf", ovf_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
